// File: rtl/axis_lfsr_checker.sv
// axis_lfsr_checker
//   AXI-Lite controlled checker for an 8-bit LFSR sequence carried on AXI-Stream.
//   Each accepted beat is compared with the successor of the previous beat
//   ({^(prev & TAPS), prev[7:1]}). Beats and errors are counted in registers.
//   Register map: 0x0 CTRL, 0x4 TAPS, 0x8 BEATS (RO), 0xC ERRORS (RO).
//   Build option: define AXIS_LFSR_CHECKER_THROTTLE_EN to enable CTRL[7:4]
//   tready throttling. Without it, CTRL[7:4] reads 0 and tready follows enable.
module axis_lfsr_checker #(
  parameter int C_AXIL_ADDR_WIDTH = 4,
  parameter int C_AXIL_DATA_WIDTH = 32
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [C_AXIL_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [C_AXIL_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [C_AXIL_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [C_AXIL_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic [C_AXIL_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready
);

  localparam int AW = C_AXIL_ADDR_WIDTH;
  localparam int DW = C_AXIL_DATA_WIDTH;

  localparam logic [AW-1:0] ADDR_CTRL   = AW'(0);
  localparam logic [AW-1:0] ADDR_TAPS   = AW'(4);
  localparam logic [AW-1:0] ADDR_BEATS  = AW'(8);
  localparam logic [AW-1:0] ADDR_ERRORS = AW'(12);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [7:0] TAPS_RESET  = 8'h87;

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_CHECK} state_t;

  state_t        state_q, state_d;
  logic          enable_q;
  logic [3:0]    throttle;
  logic [7:0]    taps_q;
  logic [7:0]    model_q;
  logic [DW-1:0] beats_q;
  logic [DW-2:0] err_cnt_q;
  logic          first_err_q;

  logic          wr_fire, wr_ctrl, wr_taps, clear_req, enable_next;
  logic          beat, take_beat, beat_err;
  logic [7:0]    exp_state;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_resp;
  logic          unused_wdata;

  assign wr_fire     = s_axi_awvalid && s_axi_awready && s_axi_wvalid && s_axi_wready;
  assign wr_ctrl     = wr_fire && (s_axi_awaddr == ADDR_CTRL);
  assign wr_taps     = wr_fire && (s_axi_awaddr == ADDR_TAPS);
  assign clear_req   = wr_ctrl && s_axi_wdata[1];
  assign enable_next = wr_ctrl ? s_axi_wdata[0] : enable_q;

  assign beat      = s_axis_tvalid && s_axis_tready;
  // A beat landing in the same cycle as a clear is dropped: clear wins.
  assign take_beat = beat && !clear_req && (state_q != ST_IDLE);
  assign exp_state = {^(model_q & taps_q), model_q[7:1]};
  assign beat_err  = (s_axis_tdata[7:0] != exp_state) || (|s_axis_tdata[DW-1:8]);

  assign unused_wdata = &{1'b0, s_axi_wdata[DW-1:2]};

  // Write channel: one-cycle ready pulse, then a response held until bready.
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!aresetn) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
      s_axi_wready  <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
      if (wr_fire) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= (wr_ctrl || wr_taps) ? RESP_OKAY : RESP_DECERR;
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  // Writable configuration: enable and taps (clear is a pulse, never stored).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      enable_q <= 1'b0;
      taps_q   <= TAPS_RESET;
    end else begin
      enable_q <= enable_next;
      if (wr_taps) taps_q <= s_axi_wdata[7:0];
    end
  end

`ifdef AXIS_LFSR_CHECKER_THROTTLE_EN
  logic [3:0] throttle_q;
  logic [3:0] gap_q;

  assign throttle = throttle_q;

  // Throttle field storage.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) throttle_q <= 4'd0;
    else if (wr_ctrl) throttle_q <= s_axi_wdata[7:4];
  end

  // tready: follows enable, but drops for 'throttle' cycles after every accept.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axis_tready <= 1'b0;
      gap_q         <= 4'd0;
    end else if (!enable_next) begin
      s_axis_tready <= 1'b0;
      gap_q         <= 4'd0;
    end else if (beat && (throttle != 4'd0)) begin
      s_axis_tready <= 1'b0;
      gap_q         <= throttle - 4'd1;
    end else if (!s_axis_tready && (gap_q != 4'd0)) begin
      gap_q         <= gap_q - 4'd1;
    end else begin
      s_axis_tready <= 1'b1;
    end
  end
`else
  assign throttle = 4'd0;

  // tready: registered copy of enable.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) s_axis_tready <= 1'b0;
    else          s_axis_tready <= enable_next;
  end
`endif

  // Checker FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Checker FSM next state: clear and enable changes override beat progress.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    if (clear_req) begin
      state_d = enable_next ? ST_SYNC : ST_IDLE;
    end else if (!enable_next) begin
      state_d = ST_IDLE;
    end else if (!enable_q) begin
      state_d = ST_SYNC;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_SYNC;
        ST_SYNC:  if (beat) state_d = ST_CHECK;
        default:  state_d = ST_CHECK;
      endcase
    end
  end

  // Datapath: model reload, beat counter (wrapping), error counter (saturating).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      model_q     <= 8'h00;
      beats_q     <= '0;
      err_cnt_q   <= '0;
      first_err_q <= 1'b0;
    end else if (clear_req) begin
      beats_q     <= '0;
      err_cnt_q   <= '0;
      first_err_q <= 1'b0;
    end else if (take_beat) begin
      model_q <= s_axis_tdata[7:0];
      beats_q <= beats_q + 1'b1;
      if ((state_q == ST_CHECK) && beat_err) begin
        first_err_q <= 1'b1;
        if (err_cnt_q != {(DW-1){1'b1}}) err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  // Read decode of the register map.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_DECERR;
    if (s_axi_araddr == ADDR_CTRL) begin
      rd_data = DW'({throttle, 3'b000, enable_q});
      rd_resp = RESP_OKAY;
    end else if (s_axi_araddr == ADDR_TAPS) begin
      rd_data = DW'(taps_q);
      rd_resp = RESP_OKAY;
    end else if (s_axi_araddr == ADDR_BEATS) begin
      rd_data = beats_q;
      rd_resp = RESP_OKAY;
    end else if (s_axi_araddr == ADDR_ERRORS) begin
      rd_data = {first_err_q, err_cnt_q};
      rd_resp = RESP_OKAY;
    end
  end

  // Read channel: one-cycle arready pulse, registered data held until rready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
      if (s_axi_arvalid && s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_resp;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/axis_lfsr_checker.md
AXIS_LFSR_CHECKER -- requirements
Module: axis_lfsr_checker
Interface
REQ-001 C_AXIL_ADDR_WIDTH, default 4, AXI-Lite address width.
REQ-002 C_AXIL_DATA_WIDTH, default 32, AXI-Lite and AXI-Stream data width.
REQ-003 aclk  in  1  single clock; all logic rising-edge.
REQ-004 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-005 s_axi_awaddr  in  4  write address.
REQ-006 s_axi_awvalid / s_axi_awready  in / out  1  write address handshake.
REQ-007 s_axi_wdata  in  32  write data.
REQ-008 s_axi_wvalid / s_axi_wready  in / out  1  write data handshake.
REQ-009 s_axi_bresp  out  2  write response: 00 OKAY, 11 DECERR.
REQ-010 s_axi_bvalid / s_axi_bready  out / in  1  write response handshake.
REQ-011 s_axi_araddr  in  4  read address.
REQ-012 s_axi_arvalid / s_axi_arready  in / out  1  read address handshake.
REQ-013 s_axi_rdata  out  32  read data.
REQ-014 s_axi_rresp  out  2  read response: 00 OKAY, 11 DECERR.
REQ-015 s_axi_rvalid / s_axi_rready  out / in  1  read data handshake.
REQ-016 s_axis_tdata  in  32  stream word from upstream LFSR generator; [7:0] LFSR state, [31:8] must be zero.
REQ-017 s_axis_tvalid / s_axis_tready  in / out  1  stream handshake; beat accepted when both high at a rising edge.
Function
REQ-018 Register map SHALL be: 0x0 CTRL (RW: bit0 enable, bit1 clear, self-clearing, reads 0; bits[7:4] throttle), 0x4 TAPS (RW, [7:0], reset 0x87), 0x8 BEATS (RO, 32-bit), 0xC ERRORS (RO, 32-bit, bit31 reads sticky first_err flag and bits[30:0] saturating count).
REQ-019 AXI-Lite write SHALL be accepted when awvalid and wvalid are both high and bvalid is low; awready and wready pulse high one cycle; bvalid rises the next cycle and holds until bready.
REQ-020 Writes to 0x8, 0xC or unmapped addresses SHALL leave state unchanged and return DECERR; writes to 0x0/0x4 return OKAY.
REQ-021 AXI-Lite read SHALL be accepted when arvalid high and rvalid low; arready pulses one cycle; rdata/rresp registered with rvalid the next cycle; rvalid holds, rdata stable, until rready.
REQ-022 Checker FSM SHALL have states IDLE, SYNC, CHECK; IDLE when enable=0; enable 0->1 goes to SYNC; first accepted beat in SYNC loads model <= tdata[7:0], counts it, goes to CHECK.
REQ-023 In CHECK each accepted beat SHALL be compared with expected = {^(model & TAPS), model[7:1]}; model then loads tdata[7:0] (resync on mismatch); BEATS increments.
REQ-024 A beat SHALL be an error if tdata[7:0] != expected or tdata[31:8] != 0; error increments ERRORS[30:0] (saturating at 0x7FFF_FFFF) and sets first_err.
REQ-025 BEATS SHALL wrap from 0xFFFF_FFFF to 0.
REQ-026 Writing clear=1 SHALL zero BEATS, ERRORS, first_err and move FSM to SYNC (IDLE if enable written 0); a beat accepted in the same cycle SHALL be discarded (clear wins).
REQ-027 enable=0 mid-stream SHALL drive tready low the next cycle and go to IDLE; counters hold.
REQ-028 s_axis_tready SHALL be registered, high only when enable=1 (subject to REQ-033).
Reset
REQ-029 On aresetn low all outputs SHALL go to 0 asynchronously: awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, tready.
REQ-030 Reset SHALL set enable=0, throttle=0, TAPS=0x87, model=0x00, BEATS=0, ERRORS=0, first_err=0, FSM=IDLE; reset mid-transaction abandons it with no response.
Configuration
REQ-031 Macro AXIS_LFSR_CHECKER_THROTTLE_EN SHALL gate the backpressure feature.
REQ-032 Without the macro CTRL[7:4] SHALL read 0, ignore writes, and tready = enable.
REQ-033 With the macro, after each accepted beat tready SHALL stay low for CTRL[7:4] cycles (0 = no gaps) before reasserting.
Verification
REQ-034 Reset, read 0x4 -> rdata 0x87, rresp 00; read 0x8 -> 0; tready 0.
REQ-035 TAPS=0xB8, enable, stream seed 0x01 and next 9 LFSR states -> BEATS 10, ERRORS 0x0000_0000.
REQ-036 Same stream with beat 5 = 0xFF -> ERRORS 0x8000_0002 (bad beat and resync beat after it), BEATS 10.
REQ-037 Beat 0x0000_0101 -> error counted; write 0x8 -> bresp 11, BEATS unchanged; read 0x10-range alias 0xE -> rresp 11.
REQ-038 Clear written coincident with accepted beat -> BEATS 0, ERRORS 0, FSM SYNC, next beat not checked.
REQ-039 With macro, throttle=3, tvalid held high -> exactly 3 low-tready cycles between consecutive accepts.
